// File: rtl/gate_pkg.sv
// Shared definitions for the gate-array accumulator: op encoding and FSM state.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package gate_pkg;

  localparam int OP_W = 3;

  // Ops 6 and 7 are intentionally left unnamed; they are treated as illegal.
  typedef enum logic [OP_W-1:0] {
    OP_OR   = 3'd0,
    OP_AND  = 3'd1,
    OP_XOR  = 3'd2,
    OP_NOR  = 3'd3,
    OP_NAND = 3'd4,
    OP_XNOR = 3'd5
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_e;

endpackage

// File: rtl/gate_reduce.sv
// Bitwise NIN-way reduction of packed operands under a selectable logic op.
// Latency: purely combinational.
// Backpressure: none; result follows the inputs.
module gate_reduce
  import gate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NIN   = 4
) (
  input  logic [NIN*WIDTH-1:0] operands,
  input  logic [OP_W-1:0]      op,
  output logic [WIDTH-1:0]     result,
  output logic                 illegal
);

  logic [WIDTH-1:0] or_r;
  logic [WIDTH-1:0] and_r;
  logic [WIDTH-1:0] xor_r;

  // Fold every operand into OR/AND/XOR partials; inverted ops reuse them.
  always_comb begin
    or_r  = '0;
    and_r = '1;
    xor_r = '0;
    for (int k = 0; k < NIN; k++) begin
      or_r  = or_r  | operands[k*WIDTH +: WIDTH];
      and_r = and_r & operands[k*WIDTH +: WIDTH];
      xor_r = xor_r ^ operands[k*WIDTH +: WIDTH];
    end
  end

  // Select the requested op; unknown encodings give zero and raise illegal.
  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (op)
      OP_OR:   result = or_r;
      OP_AND:  result = and_r;
      OP_XOR:  result = xor_r;
      OP_NOR:  result = ~or_r;
      OP_NAND: result = ~and_r;
      OP_XNOR: result = ~xor_r;
      default: begin
        result  = '0;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/gate_array_acc.sv
// Reduces each input beat with a logic op and ORs beats of a sequence into one result.
// Latency: 1 cycle from the closing beat's handshake to out_valid.
// Backpressure: in_ready = !out_valid || out_ready; held result is stable until taken.
module gate_array_acc
  import gate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NIN   = 4,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NIN*WIDTH-1:0] in_data,
  input  logic [OP_W-1:0]      op,
  input  logic                 accum,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_any,
  output logic [CNT_W-1:0]     out_count,
  output logic                 out_err
);

  state_e           state;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             err;

  logic [WIDTH-1:0] beat_res;
  logic             beat_ill;
  logic             xfer;
  logic             hold;      // beat continues a sequence without producing output
  logic [CNT_W-1:0] cnt_inc;
  logic [WIDTH-1:0] fold_data;
  logic [CNT_W-1:0] fold_cnt;
  logic             fold_err;

  gate_reduce #(
    .WIDTH (WIDTH),
    .NIN   (NIN)
  ) u_reduce (
    .operands (in_data),
    .op       (op),
    .result   (beat_res),
    .illegal  (beat_ill)
  );

  assign in_ready = !out_valid || out_ready;
  assign xfer     = in_valid && in_ready;
  assign hold     = accum && !in_last;
  assign out_any  = |out_data;

  // Fold the current beat into whatever the sequence has gathered so far.
  always_comb begin
    cnt_inc   = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
    fold_data = beat_res;
    fold_cnt  = CNT_W'(1);
    fold_err  = beat_ill;
    if (state == ST_ACC) begin
      fold_data = acc | beat_res;
      fold_cnt  = cnt_inc;
      fold_err  = err | beat_ill;
    end
  end

  // Sequence FSM plus output register; a new result may load on the edge the old one leaves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      acc       <= '0;
      cnt       <= '0;
      err       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      out_err   <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (xfer) begin
        if (hold) begin
          acc   <= fold_data;
          cnt   <= fold_cnt;
          err   <= fold_err;
          state <= ST_ACC;
        end else begin
          out_valid <= 1'b1;
          out_data  <= fold_data;
          out_count <= fold_cnt;
          out_err   <= fold_err;
          acc       <= '0;
          cnt       <= '0;
          err       <= 1'b0;
          state     <= ST_IDLE;
        end
      end
    end
  end

endmodule
